// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b, one bit per clock, LSB first.
// A single full-adder cell computes a + ~b + 1 with the carry held in a
// register between bit slices. Results are published on the final edge
// together with a one-cycle done pulse.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST    = CW'(WIDTH - 1);
    localparam logic [CW-1:0] LAST_M1 = CW'(WIDTH - 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             c_msb;
    logic [CW-1:0]    count;

    logic             nb;
    logic             s;
    logic             cout;
    logic [WIDTH-1:0] result_next;

    // One full-adder slice on the current LSBs: a + ~b + carry.
    always_comb begin
        nb          = ~sh_b[0];
        s           = sh_a[0] ^ nb ^ carry;
        cout        = (sh_a[0] & nb) | (sh_a[0] & carry) | (nb & carry);
        result_next = {s, result[WIDTH-1:1]};
    end

    // Control FSM and serial datapath; all outputs registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            ready    <= 1'b1;
            done     <= 1'b0;
            diff     <= '0;
            borrow   <= 1'b0;
            overflow <= 1'b0;
            sh_a     <= '0;
            sh_b     <= '0;
            result   <= '0;
            carry    <= 1'b0;
            c_msb    <= 1'b0;
            count    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sh_a   <= a;
                        sh_b   <= b;
                        result <= '0;
                        carry  <= 1'b1;     // the +1 of two's-complement negation
                        count  <= '0;
                        ready  <= 1'b0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    sh_a   <= sh_a >> 1;
                    sh_b   <= sh_b >> 1;
                    result <= result_next;
                    carry  <= cout;
                    count  <= count + 1'b1;
                    // Carry out of bit WIDTH-2 is the carry into the sign bit.
                    if (count == LAST_M1)
                        c_msb <= cout;
                    if (count == LAST) begin
                        diff     <= result_next;
                        borrow   <= ~cout;
                        overflow <= c_msb ^ cout;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor: computes diff = a - b one bit per clock, LSB first, with a single full-adder cell and a registered carry (a + ~b + 1).
- Inverse-direction companion to the combinational full-adder/N-bit adder path in the ALU.
- Trades WIDTH cycles of latency for one-bit datapath area.
- Start/ready/done handshake with the ALU control sequencer.

Parameters:
- WIDTH, 8, operand and result width in bits (>= 2).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  request; sampled only when ready=1
- a  input  WIDTH  minuend, captured on accepted start
- b  input  WIDTH  subtrahend, captured on accepted start
- ready  output  1  high when idle and able to accept start
- done  output  1  one-cycle pulse, result valid
- diff  output  WIDTH  a - b modulo 2^WIDTH
- borrow  output  1  unsigned borrow (1 when a < b unsigned)
- overflow  output  1  two's-complement signed overflow

Behaviour:
- Reset: one clock, one reset, synchronous active-low reset (rst_n sampled on rising clk).
- Reset values: state=IDLE, ready=1, done=0, diff=0, borrow=0, overflow=0, internal shift registers, carry and counter cleared.
- States:
  - IDLE: ready=1.
  - RUN: ready=0.
  - DONE: ready=0, done=1.
- IDLE -> RUN on edge where start=1.
  - Latch a into shift reg A and b into shift reg B.
  - Set carry=1, counter=0, working result=0.
- RUN, each edge:
  - s = A[0] ^ ~B[0] ^ carry; carry <= majority(A[0], ~B[0], carry).
  - Shift A and B right by 1; shift s into working result MSB (result >> 1, s at bit WIDTH-1).
  - counter++.
  - On the edge processing bit WIDTH-2, record carry-in to MSB (c_msb).
- RUN -> DONE on the edge processing bit WIDTH-1 (counter==WIDTH-1). On that same edge:
  - diff <= final result.
  - borrow <= ~carry_out.
  - overflow <= c_msb ^ carry_out.
- DONE -> IDLE unconditionally on the next edge.
- Latency: start accepted at edge E0; diff/borrow/overflow updated at edge E_WIDTH; done high for exactly the cycle after E_WIDTH; ready returns at E_WIDTH+1.
  - Start-to-start throughput: WIDTH+2 cycles.
- Outputs diff/borrow/overflow hold their value until the next completion or reset. They do not change during RUN.
- start while ready=0 (RUN or DONE): ignored, no queuing. a/b changes during RUN have no effect.
- start held high continuously: a new operation is accepted on each edge where ready=1, i.e. immediately after DONE.
- rst_n low mid-RUN or in DONE: abort. Next cycle state=IDLE, all outputs at reset values, and no done pulse for the aborted operation.
- rst_n has priority over start on the same edge.
- Arithmetic is modulo 2^WIDTH.
  - borrow is the unsigned view.
  - overflow is the signed view: set iff a and b differ in sign and diff's sign differs from a.

Test Plan (WIDTH=8):
- 5 - 3 -> done pulse exactly 8 cycles after start edge; diff=0x02, borrow=0, overflow=0; ready high one cycle after done.
- 3 - 5 -> diff=0xFE, borrow=1, overflow=0; 0x00 - 0x00 -> diff=0x00, borrow=0, overflow=0.
- 0x80 - 0x01 -> diff=0x7F, borrow=0, overflow=1; 0x7F - 0xFF -> diff=0x80, borrow=1, overflow=1.
- Start 0x10-0x01, then pulse start with 0xFF-0x00 at cycles 3 and 9 (RUN/DONE) -> single done, diff=0x0F; second request ignored; diff holds 0x0F through later idle cycles.
- Start 0x20-0x10, drop rst_n at cycle 4 for one cycle -> no done pulse; diff=0, borrow=0, overflow=0, ready=1; new start 0x09-0x0A -> diff=0xFF, borrow=1.
- start held high, operands changing every cycle -> each result matches the a/b captured at its accept edge; accepts spaced exactly 10 cycles; exhaustive random compare vs a-b over 1000 operations.
